rom_loader: RTL

Download front end between `hps_io`'s ioctl stream and the `scv` ROM initialisation ports. It decodes the ioctl index into boot, character and cartridge regions and rebases addresses per region. It paces the HPS with `IOCTL_WAIT`, emits one-cycle `ROMINIT_VALID` write strobes, and holds `ROMINIT_ACTIVE` (which keeps the system in reset) until the last write has drained. It also measures the loaded cartridge size for the automatic mapper selection.

---
 rtl/scv_pkg.sv | 30 +++
 rtl/rom_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scv_pkg.sv
// Shared types and size constants for the SCV ROM download path.
package scv_pkg;

    localparam int SCV_BOOT_BYTES = 4096;
    localparam int SCV_CHR_BYTES  = 1024;
    localparam int SCV_CART_MAX   = 131072;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_BOOT,
        REG_CHR,
        REG_CART
    } rominit_region_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_TAIL,
        ST_BLOCK
    } loader_state_t;

    // Source of the current session, latched from the ioctl index.
    typedef enum logic [1:0] {
        SRC_BOOT,
        SRC_CART,
        SRC_IGNORE
    } ioctl_src_t;

endpackage

// File: rtl/rom_loader.sv
// ioctl download front end: decodes the file index into boot/chr/cart regions,
// paces the HPS via IOCTL_WAIT and issues one-cycle ROMINIT write strobes.
module rom_loader
    import scv_pkg::*;
#(
    parameter int BOOT_BYTES  = SCV_BOOT_BYTES,
    parameter int CHR_BYTES   = SCV_CHR_BYTES,
    parameter int CART_MAX    = SCV_CART_MAX,
    parameter int WR_GAP      = 2,
    parameter int TAIL_CYCLES = 16
) (
    input  logic          CLK_SYS,
    input  logic          RESET,
    input  logic          IOCTL_DOWNLOAD,
    input  logic [7:0]    IOCTL_INDEX,
    input  logic          IOCTL_WR,
    input  logic [24:0]   IOCTL_ADDR,
    input  logic [7:0]    IOCTL_DOUT,
    output logic          IOCTL_WAIT,
    output logic          ROMINIT_ACTIVE,
    output logic          ROMINIT_SEL_BOOT,
    output logic          ROMINIT_SEL_CHR,
    output logic          ROMINIT_SEL_CART,
    output logic [16:0]   ROMINIT_ADDR,
    output logic [7:0]    ROMINIT_DATA,
    output logic          ROMINIT_VALID,
    output logic [17:0]   CART_SIZE,
    output logic          CART_LOADED,
    output logic          OVERRUN,
    output loader_state_t DBG_STATE
);

    localparam int GAP_W  = $clog2(WR_GAP + 1);
    localparam int TAIL_W = $clog2(TAIL_CYCLES + 1);

    loader_state_t   r_state;
    loader_state_t   w_state_next;
    logic            r_fresh;
    ioctl_src_t      r_src;
    ioctl_src_t      w_src_new;
    logic [GAP_W-1:0]  r_gap;
    logic [GAP_W-1:0]  w_gap_next;
    logic [TAIL_W-1:0] r_tail;
    logic            r_skid_full;
    logic            w_skid_next;
    logic [24:0]     r_skid_addr;
    logic [7:0]      r_skid_data;
    logic            r_valid;
    rominit_region_t r_sel;
    logic [16:0]     r_addr;
    logic [7:0]      r_data;
    logic [17:0]     r_cart_size;
    logic            r_cart_loaded;
    logic            r_overrun;

    logic            w_accept;
    logic            w_skid_go;
    logic            w_direct;
    logic            w_issue;
    logic            w_capture;
    logic            w_drop;
    logic            w_pending_next;
    logic            w_start;
    logic            w_finish_load;
    logic [24:0]     w_iss_addr;
    logic [7:0]      w_iss_data;
    rominit_region_t w_region;
    logic [16:0]     w_rel;
    logic            w_oor;
    logic [17:0]     w_cart_end;
    logic            w_unused_idx;

    assign w_unused_idx = &{1'b0, IOCTL_INDEX[7:6]};

    always_comb begin
        w_src_new = SRC_IGNORE;
        case (IOCTL_INDEX[5:0])
            6'd0:    w_src_new = SRC_BOOT;
            6'd1:    w_src_new = SRC_CART;
            default: w_src_new = SRC_IGNORE;
        endcase
    end

    // The skid entry has priority over a fresh strobe; a fresh strobe that cannot
    // be issued directly replaces the skid entry only when that entry leaves.
    assign w_accept   = (r_state == ST_LOAD) && IOCTL_WR;
    assign w_skid_go  = r_skid_full && (r_gap == '0);
    assign w_direct   = w_accept && (r_gap == '0) && !r_skid_full;
    assign w_issue    = w_skid_go || w_direct;
    assign w_capture  = w_accept && !w_direct && (!r_skid_full || w_skid_go);
    assign w_drop     = w_accept && r_skid_full && !w_skid_go;
    assign w_iss_addr = w_skid_go ? r_skid_addr : IOCTL_ADDR;
    assign w_iss_data = w_skid_go ? r_skid_data : IOCTL_DOUT;

    always_comb begin
        w_skid_next = r_skid_full;
        if (w_capture)
            w_skid_next = 1'b1;
        else if (w_skid_go)
            w_skid_next = 1'b0;
        w_gap_next = '0;
        if (w_issue)
            w_gap_next = GAP_W'(WR_GAP);
        else if (r_gap != '0)
            w_gap_next = r_gap - GAP_W'(1);
    end

    assign w_pending_next = (w_gap_next != '0) || w_skid_next;

    always_comb begin
        w_region = REG_NONE;
        w_rel    = '0;
        case (r_src)
            SRC_BOOT: begin
                if (w_iss_addr < 25'(BOOT_BYTES)) begin
                    w_region = REG_BOOT;
                    w_rel    = w_iss_addr[16:0];
                end else if (w_iss_addr < 25'(BOOT_BYTES + CHR_BYTES)) begin
                    w_region = REG_CHR;
                    w_rel    = 17'(w_iss_addr - 25'(BOOT_BYTES));
                end
            end
            SRC_CART: begin
                if (w_iss_addr < 25'(CART_MAX)) begin
                    w_region = REG_CART;
                    w_rel    = w_iss_addr[16:0];
                end
            end
            default: begin
                w_region = REG_NONE;
                w_rel    = '0;
            end
        endcase
    end

    assign w_oor      = (r_src != SRC_IGNORE) && (w_region == REG_NONE);
    assign w_cart_end = {1'b0, w_rel} + 18'd1;

    always_comb begin
        w_state_next  = r_state;
        w_start       = 1'b0;
        w_finish_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (IOCTL_DOWNLOAD) begin
                    if (r_fresh) begin
                        w_state_next = ST_BLOCK;
                    end else begin
                        w_state_next = ST_LOAD;
                        w_start      = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (!IOCTL_DOWNLOAD) begin
                    w_finish_load = 1'b1;
                    w_state_next  = w_pending_next ? ST_DRAIN : ST_TAIL;
                end
            end
            ST_DRAIN: begin
                if (!w_pending_next)
                    w_state_next = ST_TAIL;
            end
            ST_TAIL: begin
                if (IOCTL_DOWNLOAD) begin
                    w_state_next = ST_LOAD;
                    w_start      = 1'b1;
                end else if (r_tail == '0) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_BLOCK: begin
                if (!IOCTL_DOWNLOAD)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_SYS or posedge RESET) begin
        if (RESET) begin
            r_state       <= ST_IDLE;
            r_fresh       <= 1'b1;
            r_src         <= SRC_IGNORE;
            r_gap         <= '0;
            r_tail        <= '0;
            r_skid_full   <= 1'b0;
            r_skid_addr   <= '0;
            r_skid_data   <= '0;
            r_valid       <= 1'b0;
            r_sel         <= REG_NONE;
            r_addr        <= '0;
            r_data        <= '0;
            r_cart_size   <= '0;
            r_cart_loaded <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_fresh     <= 1'b0;
            r_gap       <= w_gap_next;
            r_skid_full <= w_skid_next;
            if (w_capture) begin
                r_skid_addr <= IOCTL_ADDR;
                r_skid_data <= IOCTL_DOUT;
            end
            if (w_start)
                r_src <= w_src_new;

            // Tail length counts from the first cycle with nothing left pending.
            if (w_state_next == ST_TAIL && r_state != ST_TAIL)
                r_tail <= TAIL_W'(TAIL_CYCLES - 1);
            else if (r_state == ST_TAIL && r_tail != '0)
                r_tail <= r_tail - TAIL_W'(1);

            r_valid <= w_issue && (w_region != REG_NONE);
            r_sel   <= w_issue ? w_region : REG_NONE;
            if (w_issue && w_region != REG_NONE) begin
                r_addr <= w_rel;
                r_data <= w_iss_data;
            end

            if (w_start && w_src_new == SRC_CART)
                r_cart_size <= '0;
            else if (w_issue && w_region == REG_CART && w_cart_end > r_cart_size)
                r_cart_size <= w_cart_end;

            if (w_start && w_src_new == SRC_CART)
                r_cart_loaded <= 1'b0;
            else if (w_finish_load && r_src == SRC_CART)
                r_cart_loaded <= 1'b1;

            if (w_start)
                r_overrun <= 1'b0;
            else if (w_drop || (w_issue && w_oor))
                r_overrun <= 1'b1;
        end
    end

    assign IOCTL_WAIT       = (r_gap != '0) || r_skid_full;
    assign ROMINIT_ACTIVE   = (r_state == ST_LOAD) || (r_state == ST_DRAIN) ||
                              (r_state == ST_TAIL);
    assign ROMINIT_VALID    = r_valid;
    assign ROMINIT_SEL_BOOT = (r_sel == REG_BOOT);
    assign ROMINIT_SEL_CHR  = (r_sel == REG_CHR);
    assign ROMINIT_SEL_CART = (r_sel == REG_CART);
    assign ROMINIT_ADDR     = r_addr;
    assign ROMINIT_DATA     = r_data;
    assign CART_SIZE        = r_cart_size;
    assign CART_LOADED      = r_cart_loaded;
    assign OVERRUN          = r_overrun;
    // A fresh reset with the download still high behaves as BLOCK from the start.
    assign DBG_STATE = (r_state == ST_IDLE && r_fresh && IOCTL_DOWNLOAD) ? ST_BLOCK : r_state;

endmodule
